load_store_queue: RTL and testbench

LOAD_STORE_QUEUE -- requirements
Module: load_store_queue

---
 rtl/load_store_queue_pkg.sv | 25 ++
 rtl/load_store_queue_operand_capture.sv | 33 +++
 rtl/load_store_queue.sv | 230 +++++++++++++++++++++++
 tb/tb_load_store_queue.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/load_store_queue_pkg.sv
// rtl/load_store_queue_pkg.sv - shared sizes, type-field encodings and FSM states for the load/store queue
package load_store_queue_pkg;

    localparam int LSB_SIZE_BIT_DEF  = 4;
    localparam int ROB_WIDTH_BIT_DEF = 4;
    localparam int LS_TYPE_BIT_DEF   = 4;

    // inst_type layout: bit3 store, bit2 sign, bits[1:0] access size
    localparam int TYPE_STORE_BIT = 3;
    localparam int TYPE_SIGN_BIT  = 2;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    typedef enum logic {
        LSQ_IDLE = 1'b0,
        LSQ_BUSY = 1'b1
    } lsq_state_t;

    function automatic logic [31:0] lsq_addr(input logic [31:0] base, input logic [11:0] offset);
        return base + {{20{offset[11]}}, offset};
    endfunction

endpackage

// File: rtl/load_store_queue_operand_capture.sv
// rtl/load_store_queue_operand_capture.sv - push-time operand bypass from the rs/lsb result broadcasts
module lsq_operand_capture #(
    parameter int ROB_WIDTH_BIT = 4
) (
    input  logic                     has_dep,
    input  logic [ROB_WIDTH_BIT-1:0] dep,
    input  logic [31:0]              value,
    input  logic                     rs_ready,
    input  logic [ROB_WIDTH_BIT-1:0] rs_rob_id,
    input  logic [31:0]              rs_value,
    input  logic                     lsb_ready,
    input  logic [ROB_WIDTH_BIT-1:0] lsb_rob_id,
    input  logic [31:0]              lsb_value,
    output logic                     out_has_dep,
    output logic [31:0]              out_value
);

    // The ALU broadcast wins when both buses carry the awaited tag.
    always_comb begin
        out_has_dep = has_dep;
        out_value   = value;
        if (has_dep) begin
            if (rs_ready && rs_rob_id == dep) begin
                out_has_dep = 1'b0;
                out_value   = rs_value;
            end else if (lsb_ready && lsb_rob_id == dep) begin
                out_has_dep = 1'b0;
                out_value   = lsb_value;
            end
        end
    end

endmodule

// File: rtl/load_store_queue.sv
// rtl/load_store_queue.sv - in-order load/store queue with operand wakeup, single outstanding cache request and flush
module load_store_queue
    import load_store_queue_pkg::*;
#(
    parameter int LSB_SIZE_BIT  = LSB_SIZE_BIT_DEF,
    parameter int ROB_WIDTH_BIT = ROB_WIDTH_BIT_DEF,
    parameter int LS_TYPE_BIT   = LS_TYPE_BIT_DEF
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     rdy_in,
    input  logic                     inst_valid,
    input  logic [LS_TYPE_BIT-1:0]   inst_type,
    input  logic [11:0]              inst_offset,
    input  logic [ROB_WIDTH_BIT-1:0] inst_rob_id,
    input  logic [31:0]              inst_r1,
    input  logic [31:0]              inst_r2,
    input  logic [ROB_WIDTH_BIT-1:0] inst_dep1,
    input  logic [ROB_WIDTH_BIT-1:0] inst_dep2,
    input  logic                     inst_has_dep1,
    input  logic                     inst_has_dep2,
    output logic                     full,
    output logic [LSB_SIZE_BIT:0]    count,
    output logic                     cache_valid,
    output logic                     cache_wr,
    output logic [2:0]               cache_size,
    output logic [31:0]              cache_addr,
    output logic [31:0]              cache_value,
    input  logic                     cache_ready,
    input  logic [31:0]              cache_res,
    input  logic                     rob_clear,
    input  logic [ROB_WIDTH_BIT-1:0] rob_id_head,
    input  logic                     rs_ready,
    input  logic [ROB_WIDTH_BIT-1:0] rs_rob_id,
    input  logic [31:0]              rs_value,
    output logic                     lsb_ready,
    output logic [ROB_WIDTH_BIT-1:0] lsb_rob_id,
    output logic [31:0]              lsb_value
);

    localparam int                    DEPTH     = 1 << LSB_SIZE_BIT;
    localparam logic [LSB_SIZE_BIT:0] DEPTH_CNT = (LSB_SIZE_BIT+1)'(DEPTH);
    localparam logic [LSB_SIZE_BIT:0] CNT_ONE   = (LSB_SIZE_BIT+1)'(1);
    localparam logic [LSB_SIZE_BIT-1:0] PTR_ONE = LSB_SIZE_BIT'(1);
    localparam logic [DEPTH-1:0]      SLOT0     = DEPTH'(1);

    lsq_state_t                state;
    logic [LSB_SIZE_BIT-1:0]   head;
    logic [LSB_SIZE_BIT-1:0]   tail;
    logic [LSB_SIZE_BIT:0]     cnt;
    logic [LSB_SIZE_BIT:0]     cnt_next;
    logic                      flush_tag;
    logic [ROB_WIDTH_BIT-1:0]  flight_rob;

    logic [DEPTH-1:0]          busy;
    logic [DEPTH-1:0]          has_dep1;
    logic [DEPTH-1:0]          has_dep2;
    logic [LS_TYPE_BIT-1:0]    e_type [DEPTH];
    logic [11:0]               e_off  [DEPTH];
    logic [ROB_WIDTH_BIT-1:0]  e_rob  [DEPTH];
    logic [ROB_WIDTH_BIT-1:0]  e_dep1 [DEPTH];
    logic [ROB_WIDTH_BIT-1:0]  e_dep2 [DEPTH];
    logic [31:0]               e_r1   [DEPTH];
    logic [31:0]               e_r2   [DEPTH];

    logic                      push_has_dep1;
    logic                      push_has_dep2;
    logic [31:0]               push_r1;
    logic [31:0]               push_r2;
    logic                      push;
    logic                      complete;
    logic                      head_ready;
    logic                      issue;

    assign full        = (cnt == DEPTH_CNT);
    assign count       = cnt;
    assign cache_valid = (state == LSQ_BUSY);
    assign complete    = cache_valid && cache_ready;

    // A flushed request, or one completing under a flush, must not wake anyone up.
    assign lsb_ready   = rdy_in && complete && !flush_tag && !rob_clear;
    assign lsb_rob_id  = lsb_ready ? flight_rob : '0;
    assign lsb_value   = (lsb_ready && !cache_wr) ? cache_res : '0;

    assign push        = rdy_in && inst_valid && !full && !rob_clear;
    assign head_ready  = busy[head] && !has_dep1[head] && !has_dep2[head] &&
                         (!e_type[head][TYPE_STORE_BIT] || e_rob[head] == rob_id_head);
    assign issue       = rdy_in && (state == LSQ_IDLE) && !rob_clear && head_ready;

    function automatic logic rs_hit(input logic [ROB_WIDTH_BIT-1:0] tag);
        return rs_ready && rs_rob_id == tag;
    endfunction

    function automatic logic dep_hit(input logic [ROB_WIDTH_BIT-1:0] tag);
        return rs_hit(tag) || (lsb_ready && lsb_rob_id == tag);
    endfunction

    function automatic logic [31:0] dep_value(input logic [ROB_WIDTH_BIT-1:0] tag);
        return rs_hit(tag) ? rs_value : lsb_value;
    endfunction

    lsq_operand_capture #(.ROB_WIDTH_BIT(ROB_WIDTH_BIT)) u_cap_r1 (
        .has_dep     (inst_has_dep1),
        .dep         (inst_dep1),
        .value       (inst_r1),
        .rs_ready    (rs_ready),
        .rs_rob_id   (rs_rob_id),
        .rs_value    (rs_value),
        .lsb_ready   (lsb_ready),
        .lsb_rob_id  (lsb_rob_id),
        .lsb_value   (lsb_value),
        .out_has_dep (push_has_dep1),
        .out_value   (push_r1)
    );

    lsq_operand_capture #(.ROB_WIDTH_BIT(ROB_WIDTH_BIT)) u_cap_r2 (
        .has_dep     (inst_has_dep2),
        .dep         (inst_dep2),
        .value       (inst_r2),
        .rs_ready    (rs_ready),
        .rs_rob_id   (rs_rob_id),
        .rs_value    (rs_value),
        .lsb_ready   (lsb_ready),
        .lsb_rob_id  (lsb_rob_id),
        .lsb_value   (lsb_value),
        .out_has_dep (push_has_dep2),
        .out_value   (push_r2)
    );

    always_comb begin
        cnt_next = cnt;
        if (push && !complete) begin
            cnt_next = cnt + CNT_ONE;
        end else if (!push && complete) begin
            cnt_next = cnt - CNT_ONE;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state       <= LSQ_IDLE;
            head        <= '0;
            tail        <= '0;
            cnt         <= '0;
            flush_tag   <= 1'b0;
            busy        <= '0;
            has_dep1    <= '0;
            has_dep2    <= '0;
            flight_rob  <= '0;
            cache_wr    <= 1'b0;
            cache_size  <= '0;
            cache_addr  <= '0;
            cache_value <= '0;
        end else if (rdy_in) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (busy[i] && has_dep1[i] && dep_hit(e_dep1[i])) has_dep1[i] <= 1'b0;
                if (busy[i] && has_dep2[i] && dep_hit(e_dep2[i])) has_dep2[i] <= 1'b0;
            end
            if (push) begin
                busy[tail]     <= 1'b1;
                has_dep1[tail] <= push_has_dep1;
                has_dep2[tail] <= push_has_dep2;
                tail           <= tail + PTR_ONE;
            end
            if (rob_clear) begin
                if (state == LSQ_BUSY && !cache_ready) begin
                    // Keep only the in-flight slot; its completion is retired silently.
                    busy      <= SLOT0 << head;
                    tail      <= head + PTR_ONE;
                    cnt       <= CNT_ONE;
                    flush_tag <= 1'b1;
                end else if (state == LSQ_BUSY) begin
                    busy      <= '0;
                    head      <= head + PTR_ONE;
                    tail      <= head + PTR_ONE;
                    cnt       <= '0;
                    flush_tag <= 1'b0;
                    state     <= LSQ_IDLE;
                end else begin
                    busy <= '0;
                    tail <= head;
                    cnt  <= '0;
                end
            end else begin
                cnt <= cnt_next;
                case (state)
                    LSQ_IDLE: begin
                        if (issue) begin
                            state       <= LSQ_BUSY;
                            flight_rob  <= e_rob[head];
                            cache_wr    <= e_type[head][TYPE_STORE_BIT];
                            cache_size  <= e_type[head][2:0];
                            cache_addr  <= lsq_addr(e_r1[head], e_off[head]);
                            cache_value <= e_r2[head];
                        end
                    end
                    LSQ_BUSY: begin
                        if (cache_ready) begin
                            busy[head] <= 1'b0;
                            head       <= head + PTR_ONE;
                            flush_tag  <= 1'b0;
                            state      <= LSQ_IDLE;
                        end
                    end
                    default: state <= LSQ_IDLE;
                endcase
            end
        end
    end

    // Payload storage carries no reset: busy/has_dep gate every use of it.
    always_ff @(posedge clk_in) begin
        if (rdy_in) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (busy[i] && has_dep1[i] && dep_hit(e_dep1[i])) e_r1[i] <= dep_value(e_dep1[i]);
                if (busy[i] && has_dep2[i] && dep_hit(e_dep2[i])) e_r2[i] <= dep_value(e_dep2[i]);
            end
            if (push) begin
                e_type[tail] <= inst_type;
                e_off[tail]  <= inst_offset;
                e_rob[tail]  <= inst_rob_id;
                e_dep1[tail] <= inst_dep1;
                e_dep2[tail] <= inst_dep2;
                e_r1[tail]   <= push_r1;
                e_r2[tail]   <= push_r2;
            end
        end
    end

endmodule

// File: tb/tb_load_store_queue.sv
// tb/tb_load_store_queue.sv - directed and randomized checks of load_store_queue against a queue-based reference model
module tb_load_store_queue;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        inst_valid;
    logic [3:0]  inst_type;
    logic [11:0] inst_offset;
    logic [3:0]  inst_rob_id;
    logic [31:0] inst_r1;
    logic [31:0] inst_r2;
    logic [3:0]  inst_dep1;
    logic [3:0]  inst_dep2;
    logic        inst_has_dep1;
    logic        inst_has_dep2;
    logic        full;
    logic [4:0]  count;
    logic        cache_valid;
    logic        cache_wr;
    logic [2:0]  cache_size;
    logic [31:0] cache_addr;
    logic [31:0] cache_value;
    logic        cache_ready;
    logic [31:0] cache_res;
    logic        rob_clear;
    logic [3:0]  rob_id_head;
    logic        rs_ready;
    logic [3:0]  rs_rob_id;
    logic [31:0] rs_value;
    logic        lsb_ready;
    logic [3:0]  lsb_rob_id;
    logic [31:0] lsb_value;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [3:0]  t;
        logic [11:0] off;
        logic [3:0]  rob;
        logic [31:0] r1;
        logic [31:0] r2;
        bit          hd1;
        bit          hd2;
        logic [3:0]  d1;
        logic [3:0]  d2;
    } ent_t;

    ent_t        mq[$];
    bit          m_inflight;
    bit          m_flushed;
    logic [31:0] m_addr;
    logic [31:0] m_value;
    logic        m_wr;
    logic [2:0]  m_size;
    logic [3:0]  m_rob;

    load_store_queue dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .rdy_in        (rdy_in),
        .inst_valid    (inst_valid),
        .inst_type     (inst_type),
        .inst_offset   (inst_offset),
        .inst_rob_id   (inst_rob_id),
        .inst_r1       (inst_r1),
        .inst_r2       (inst_r2),
        .inst_dep1     (inst_dep1),
        .inst_dep2     (inst_dep2),
        .inst_has_dep1 (inst_has_dep1),
        .inst_has_dep2 (inst_has_dep2),
        .full          (full),
        .count         (count),
        .cache_valid   (cache_valid),
        .cache_wr      (cache_wr),
        .cache_size    (cache_size),
        .cache_addr    (cache_addr),
        .cache_value   (cache_value),
        .cache_ready   (cache_ready),
        .cache_res     (cache_res),
        .rob_clear     (rob_clear),
        .rob_id_head   (rob_id_head),
        .rs_ready      (rs_ready),
        .rs_rob_id     (rs_rob_id),
        .rs_value      (rs_value),
        .lsb_ready     (lsb_ready),
        .lsb_rob_id    (lsb_rob_id),
        .lsb_value     (lsb_value)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        rdy_in = 1'b1; inst_valid = 1'b0; inst_type = '0; inst_offset = '0; inst_rob_id = '0;
        inst_r1 = '0; inst_r2 = '0; inst_dep1 = '0; inst_dep2 = '0;
        inst_has_dep1 = 1'b0; inst_has_dep2 = 1'b0; cache_ready = 1'b0; cache_res = '0;
        rob_clear = 1'b0; rob_id_head = '0; rs_ready = 1'b0; rs_rob_id = '0; rs_value = '0;
    endtask

    task automatic set_push(input logic [3:0] t, input logic [3:0] rob, input logic [31:0] r1,
                            input logic [31:0] r2, input logic [11:0] off);
        inst_valid = 1'b1; inst_type = t; inst_rob_id = rob; inst_r1 = r1; inst_r2 = r2;
        inst_offset = off; inst_has_dep1 = 1'b0; inst_has_dep2 = 1'b0;
    endtask

    // Broadcast lookup: ALU bus first, then the queue's own result bus.
    function automatic bit bc_hit(input logic [3:0] tag, input bit lr, input logic [3:0] lrob,
                                  input logic [31:0] lval, output logic [31:0] v);
        if (rs_ready && rs_rob_id == tag) begin
            v = rs_value;
            return 1'b1;
        end
        if (lr && lrob == tag) begin
            v = lval;
            return 1'b1;
        end
        v = '0;
        return 1'b0;
    endfunction

    task automatic model_step(input bit lr, input logic [3:0] lrob, input logic [31:0] lval);
        int          n0;
        bit          do_issue;
        logic [31:0] v;
        ent_t        e;
        n0 = mq.size();
        do_issue = 1'b0;
        if (n0 > 0 && !m_inflight && !rob_clear)
            do_issue = !mq[0].hd1 && !mq[0].hd2 && (!mq[0].t[3] || mq[0].rob == rob_id_head);
        foreach (mq[i]) begin
            if (mq[i].hd1 && bc_hit(mq[i].d1, lr, lrob, lval, v)) begin mq[i].hd1 = 1'b0; mq[i].r1 = v; end
            if (mq[i].hd2 && bc_hit(mq[i].d2, lr, lrob, lval, v)) begin mq[i].hd2 = 1'b0; mq[i].r2 = v; end
        end
        if (rob_clear) begin
            if (m_inflight && !cache_ready) begin
                while (mq.size() > 1) void'(mq.pop_back());
                m_flushed = 1'b1;
            end else begin
                mq.delete();
                m_inflight = 1'b0;
                m_flushed = 1'b0;
            end
        end else begin
            if (m_inflight && cache_ready) begin
                void'(mq.pop_front());
                m_inflight = 1'b0;
                m_flushed = 1'b0;
            end else if (do_issue) begin
                m_inflight = 1'b1;
                m_addr  = mq[0].r1 + {{20{mq[0].off[11]}}, mq[0].off};
                m_wr    = mq[0].t[3];
                m_size  = mq[0].t[2:0];
                m_value = mq[0].r2;
                m_rob   = mq[0].rob;
            end
            if (inst_valid && n0 < 16) begin
                e.t = inst_type; e.off = inst_offset; e.rob = inst_rob_id;
                e.r1 = inst_r1; e.r2 = inst_r2; e.hd1 = inst_has_dep1; e.hd2 = inst_has_dep2;
                e.d1 = inst_dep1; e.d2 = inst_dep2;
                if (e.hd1 && bc_hit(e.d1, lr, lrob, lval, v)) begin e.hd1 = 1'b0; e.r1 = v; end
                if (e.hd2 && bc_hit(e.d2, lr, lrob, lval, v)) begin e.hd2 = 1'b0; e.r2 = v; end
                mq.push_back(e);
            end
        end
    endtask

    // Called at a negedge with inputs already driven; returns at the next negedge.
    task automatic cycle();
        bit          lr;
        logic [3:0]  lrob;
        logic [31:0] lval;
        #1;
        check("count", 32'(count), 32'(mq.size()));
        check("full", 32'(full), 32'(mq.size() == 16));
        check("cache_valid", 32'(cache_valid), 32'(m_inflight));
        if (m_inflight) begin
            check("cache_addr", cache_addr, m_addr);
            check("cache_wr", 32'(cache_wr), 32'(m_wr));
            check("cache_size", 32'(cache_size), 32'(m_size));
            check("cache_value", cache_value, m_value);
        end
        lr   = rdy_in && m_inflight && cache_ready && !m_flushed && !rob_clear;
        lrob = lr ? m_rob : 4'd0;
        lval = (lr && !m_wr) ? cache_res : 32'd0;
        check("lsb_ready", 32'(lsb_ready), 32'(lr));
        check("lsb_rob_id", 32'(lsb_rob_id), 32'(lrob));
        check("lsb_value", lsb_value, lval);
        if (rdy_in) model_step(lr, lrob, lval);
        @(posedge clk_in);
        @(negedge clk_in);
    endtask

    task automatic do_reset();
        #2 rst_in = 1'b0;
        #1;
        check("rst_cache_valid", 32'(cache_valid), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_full", 32'(full), 32'd0);
        check("rst_lsb_ready", 32'(lsb_ready), 32'd0);
        mq.delete();
        m_inflight = 1'b0;
        m_flushed = 1'b0;
        @(negedge clk_in);
        rst_in = 1'b1;
    endtask

    initial begin
        rst_in = 1'b0;
        idle_inputs();
        do_reset();

        // Word load 0x100-4, answered three cycles after issue.
        set_push(4'b0010, 4'd1, 32'h100, 32'h0, 12'hFFC);
        cycle();
        inst_valid = 1'b0;
        cycle();
        check("ld_addr", cache_addr, 32'hFC);
        cycle();
        cycle();
        cache_ready = 1'b1; cache_res = 32'hDEAD;
        #1;
        check("ld_lsb_ready", 32'(lsb_ready), 32'd1);
        check("ld_lsb_value", lsb_value, 32'hDEAD);
        cycle();
        cache_ready = 1'b0;
        cycle();

        // Store waits for the ROB head to reach its tag.
        set_push(4'b1010, 4'd5, 32'h200, 32'h1234, 12'h010);
        rob_id_head = 4'd3;
        cycle();
        inst_valid = 1'b0;
        cycle();
        check("st_wait", 32'(cache_valid), 32'd0);
        rob_id_head = 4'd5;
        cycle();
        check("st_valid", 32'(cache_valid), 32'd1);
        check("st_wr", 32'(cache_wr), 32'd1);
        cache_ready = 1'b1;
        cycle();
        cache_ready = 1'b0;

        // Same-cycle bypass of r1 from the ALU broadcast.
        set_push(4'b0010, 4'd2, 32'hBAD0, 32'h0, 12'h008);
        inst_has_dep1 = 1'b1; inst_dep1 = 4'd7;
        rs_ready = 1'b1; rs_rob_id = 4'd7; rs_value = 32'h40;
        cycle();
        idle_inputs();
        cycle();
        check("bypass_addr", cache_addr, 32'h48);
        cache_ready = 1'b1;
        cycle();
        cache_ready = 1'b0;

        // Fill with blocked stores, overflow, then pop+push at the boundary.
        for (int i = 0; i < 16; i++) begin
            set_push(4'b1010, 4'd9, 32'(i * 4), 32'(i), 12'h0);
            cycle();
        end
        check("fill_full", 32'(full), 32'd1);
        check("fill_count", 32'(count), 32'd16);
        cycle();
        check("overflow_count", 32'(count), 32'd16);
        inst_valid = 1'b0; rob_id_head = 4'd9;
        cycle();
        inst_valid = 1'b1; cache_ready = 1'b1;
        cycle();
        check("full_poppush", 32'(count), 32'd15);
        inst_valid = 1'b0; cache_ready = 1'b0;
        cycle();
        inst_valid = 1'b1; cache_ready = 1'b1;
        cycle();
        check("poppush_count", 32'(count), 32'd15);
        inst_valid = 1'b0;
        for (int k = 0; k < 200 && mq.size() > 0; k++) begin
            cache_ready = 1'($urandom_range(0, 1));
            cycle();
        end
        check("drain_count", 32'(count), 32'd0);
        idle_inputs();

        // Flush with a load in flight and three waiting behind it.
        for (int i = 0; i < 4; i++) begin
            set_push(4'b0010, 4'(i + 1), 32'h1000, 32'h0, 12'(i * 4));
            cycle();
        end
        inst_valid = 1'b0;
        rob_clear = 1'b1;
        cycle();
        check("flush_count", 32'(count), 32'd1);
        rob_clear = 1'b0; cache_ready = 1'b1; cache_res = 32'hBEEF;
        #1;
        check("flush_no_bcast", 32'(lsb_ready), 32'd0);
        cycle();
        check("flush_drained", 32'(count), 32'd0);
        idle_inputs();

        // Asynchronous reset while a request is outstanding.
        set_push(4'b0010, 4'd3, 32'h300, 32'h0, 12'h0);
        cycle();
        inst_valid = 1'b0;
        cycle();
        check("pre_rst_valid", 32'(cache_valid), 32'd1);
        do_reset();

        for (int c = 0; c < 3000; c++) begin
            rdy_in        = ($urandom_range(0, 9) != 0);
            inst_valid    = 1'($urandom_range(0, 1));
            inst_type     = {($urandom_range(0, 9) < 3), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 2))};
            inst_offset   = 12'($urandom);
            inst_rob_id   = 4'($urandom);
            inst_r1       = $urandom;
            inst_r2       = $urandom;
            inst_has_dep1 = ($urandom_range(0, 3) == 0);
            inst_has_dep2 = ($urandom_range(0, 3) == 0);
            inst_dep1     = 4'($urandom);
            inst_dep2     = 4'($urandom);
            rs_ready      = ($urandom_range(0, 9) < 4);
            rs_rob_id     = 4'($urandom);
            rs_value      = $urandom;
            cache_ready   = ($urandom_range(0, 9) < 4);
            cache_res     = $urandom;
            rob_clear     = ($urandom_range(0, 49) == 0);
            rob_id_head   = (mq.size() > 0 && $urandom_range(0, 1) == 1) ? mq[0].rob : 4'($urandom);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
